mac_datapath: RTL
=================

Name: mac_datapath

Overview:
- Arithmetic datapath that is driven by the MAC control FSM. It consumes load_a, load_b, load_m, load_acc, load_out and count_enable, and returns cmp.
- It holds two N-entry operand vector memories, written by the host, and an element counter.
- It computes result = sum over i of A[i]*B[i], one element per controller iteration.
- It sits between the host write port and the control FSM. go is shared with the FSM.

Parameters:
- DATA_W, 8, operand width in bits.
- N, 8, vector length (elements per dot product), range 2..2^ADDR_W.
- ADDR_W, 3, memory address width.
- ACC_W, 19, accumulator and result width. The default 2*DATA_W+ADDR_W guarantees no overflow for unsigned N=8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- go  in  1  start pulse, same signal the FSM sees. Clears the accumulator and counter.
- wr_en  in  1  host write strobe for the operand memories.
- wr_sel  in  1  memory select: 0 selects A, 1 selects B.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- load_a  in  1  a_reg <= memA[cnt].
- load_b  in  1  b_reg <= memB[cnt].
- load_m  in  1  m_reg <= a_reg*b_reg.
- load_acc  in  1  acc <= acc + m_reg.
- load_out  in  1  result <= acc.
- count_enable  in  1  cnt <= cnt+1 (saturating).
- cmp  out  1  element count reached: (cnt == N). Combinational from cnt.
- result  out  ACC_W  final dot product, held until the next load_out or reset.
- result_valid  out  1  high from the cycle after load_out until the next go or reset.

Behaviour:
- Reset (async, rst=1): a_reg, b_reg, m_reg, acc, result and cnt all go to 0; result_valid=0, cmp=0. Memory contents are not reset and are undefined until written.
- Counter: cnt is ADDR_W+1 bits wide. count_enable increments it; it saturates at N (no wrap). cmp=1 exactly when cnt==N.
- Operand fetch: load_a and load_b read memA[cnt] and memB[cnt] using the pre-increment cnt value. The FSM asserts load_a, load_b and count_enable in the same cycle. Element i is therefore fetched while cnt=i, and cnt=i+1 after that edge.
  - Fetch with cnt==N (misuse): reads address cnt[ADDR_W-1:0]. No error is raised.
- Pipeline registers, each updated only on its strobe and otherwise holding:
  - a_reg, b_reg: DATA_W each.
  - m_reg: 2*DATA_W, full-width product.
  - acc: ACC_W. m_reg is zero-extended (unsigned) before the add. acc wraps modulo 2^ACC_W on overflow; no flag.
- Controller iteration timing: fetch in S1, multiply in S3, accumulate in S5. Each stage's source register was written at least one cycle earlier.
- go=1 (any cycle): acc<=0, cnt<=0, result_valid<=0. result keeps its old value.
  - go has priority over count_enable and load_acc in the same cycle.
- load_out: result<=acc; result_valid<=1 on the next edge.
  - load_out and load_acc in the same cycle: result takes the pre-add acc.
- Host writes:
  - Writes are accepted any cycle, one per cycle.
  - Write and fetch to the same address in the same cycle: the fetch returns old data (read-before-write).
  - Writes during an active computation are legal; the result then uses whatever data is present at each fetch.
- End-to-end latency: go to result_valid equals the FSM latency, 6 cycles per element plus 3 cycles overhead. The datapath adds no cycles of its own beyond the register updates.
- Reset mid-operation: all registers clear immediately and cmp drops. The FSM also resets, so no partial result is exposed.

Optional Feature:
- MAC_SIGNED_EN defined:
  - Operands are two's complement.
  - m_reg = signed a_reg*b_reg.
  - m_reg is sign-extended into the acc add; result is signed.
- MAC_SIGNED_EN undefined: all arithmetic is unsigned and zero-extended.
- Counter, cmp and handshake timing are identical in both modes.

Test Plan:
- Unsigned dot product: write A={1..8}, B=all 1; pulse go; drive the FSM sequence -> cmp=1 after the 8th count_enable, result=36, result_valid=1.
- Max-value overflow check: A=B=all 255, N=8 -> result=520200 (fits 19 bits, 2^19=524288); no wrap.
- Counter saturation: issue 10 count_enable pulses with no go -> cnt stays 8 and cmp stays 1. Then pulse go -> cmp=0 next cycle, result unchanged, result_valid=0.
- Write/read collision: write memA[0]=5 in the same cycle as a fetch at cnt=0, with old memA[0]=3 -> a_reg=3; the next fetch of address 0 gives 5.
- Signed mode (MAC_SIGNED_EN): A=all 0xFF (-1), B=all 2 -> result = -16 (0x7FFF0 in 19 bits).
- Reset mid-operation: assert rst after the 4th load_acc -> acc, cnt, result and result_valid are 0 immediately. A fresh go with A={1..8}, B=all 1 then gives 36.

Source files
------------

// File: rtl/mac_datapath.sv
// mac_datapath: operand memories, element counter and multiply-accumulate
// pipeline for the MAC controller. The FSM supplies the load strobes and
// count_enable; this block returns cmp once every element has been fetched.
//
// Optional build macro:
//   MAC_SIGNED_EN - operands are two's complement, the product is signed and
//                   is sign-extended into the accumulator. Without it, all
//                   arithmetic is unsigned and zero-extended.
module mac_datapath #(
    parameter int DATA_W = 8,
    parameter int N      = 8,
    parameter int ADDR_W = 3,
    parameter int ACC_W  = 2*DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              load_m,
    input  logic              load_acc,
    input  logic              load_out,
    input  logic              count_enable,
    output logic              cmp,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid
);

    localparam int              PROD_W  = 2*DATA_W;
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_N   = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    // Operand storage; contents are never reset.
    logic [DATA_W-1:0] mem_a [0:DEPTH-1];
    logic [DATA_W-1:0] mem_b [0:DEPTH-1];

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [PROD_W-1:0] m_q, m_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              valid_q, valid_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // A fetch at cnt==N simply uses the low address bits; no error is flagged.
    logic [ADDR_W-1:0] rd_addr;
    assign rd_addr = cnt_q[ADDR_W-1:0];

    // Operands widened to product width, and product widened to acc width.
    logic [PROD_W-1:0] a_ext, b_ext, prod;
    logic [ACC_W-1:0]  m_ext;

`ifdef MAC_SIGNED_EN
    assign a_ext = {{DATA_W{a_q[DATA_W-1]}}, a_q};
    assign b_ext = {{DATA_W{b_q[DATA_W-1]}}, b_q};
    assign m_ext = {{(ACC_W-PROD_W){m_q[PROD_W-1]}}, m_q};
`else
    assign a_ext = {{DATA_W{1'b0}}, a_q};
    assign b_ext = {{DATA_W{1'b0}}, b_q};
    assign m_ext = {{(ACC_W-PROD_W){1'b0}}, m_q};
`endif

    // Low PROD_W bits of the widened product are exact in both modes.
    assign prod = a_ext * b_ext;

    // Host write port; nonblocking writes give read-before-write on collision.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_sel) begin
            mem_a[wr_addr] <= wr_data;
        end
        if (wr_en && wr_sel) begin
            mem_b[wr_addr] <= wr_data;
        end
    end

    // Next-state for every pipeline register; go overrides counting and accumulating.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;

        if (load_a) begin
            a_d = mem_a[rd_addr];
        end
        if (load_b) begin
            b_d = mem_b[rd_addr];
        end
        if (load_m) begin
            m_d = prod;
        end
        // Captures the pre-add accumulator when load_acc fires in the same cycle.
        if (load_out) begin
            result_d = acc_q;
            valid_d  = 1'b1;
        end

        if (go) begin
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (load_acc) begin
                acc_d = acc_q + m_ext;
            end
            if (count_enable && (cnt_q != CNT_N)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cmp          = (cnt_q == CNT_N);
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule
